i2c_byte_engine: RTL

Bit-level I2C master PHY directly below the I2C soft-core. It turns single-cycle byte commands (start+address, write, read, stop) into open-drain SCL/SDA waveforms and reports ACK and received data back to the core. It is single-master with 7-bit addressing, and it tolerates slave clock stretching.

---
 rtl/i2c_pkg.sv | 40 ++++
 rtl/i2c_tick_gen.sv | 31 +++
 rtl/i2c_byte_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C byte engine and the soft-core above it:
// state and quarter encodings, command priority and default divider.
package i2c_pkg;

  localparam int unsigned DEF_CLK_DIV = 30;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_RSTART = 3'd2;
  localparam logic [2:0] ST_BIT    = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_HOLD   = 3'd6;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_WRITE,
    CMD_READ
  } cmd_e;

  // Simultaneous commands resolve as start > stop > write > read.
  function automatic cmd_e f_cmd_sel(input logic i_start, input logic i_stop,
                                     input logic i_write, input logic i_read);
    cmd_e v_cmd;
    v_cmd = CMD_NONE;
    if (i_start)      v_cmd = CMD_START;
    else if (i_stop)  v_cmd = CMD_STOP;
    else if (i_write) v_cmd = CMD_WRITE;
    else if (i_read)  v_cmd = CMD_READ;
    return v_cmd;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit divider: counts 0..CLK_DIV-1 while enabled, freezes on hold,
// and flags the last count of each quarter.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_hold,
  output logic o_tick
);

  logic [9:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == 10'(CLK_DIV - 1));
  assign o_tick = i_en && !i_hold && w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (!i_hold) begin
      r_cnt <= w_last ? '0 : r_cnt + 10'd1;
    end
  end

endmodule

// File: rtl/i2c_byte_engine.sv
// Bit-level I2C master PHY: turns start/write/read/stop byte commands into
// open-drain SCL/SDA waveforms, reporting ACK and received data.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nReset,
  inout  wire        scl,
  inout  wire        sda,
  input  logic [7:0] dIn,
  input  logic       readNWrite,
  input  logic       start,
  input  logic       write,
  input  logic       read,
  input  logic       stop,
  input  logic       sendAck,
  output logic [7:0] dOut,
  output logic       dOutStrobe,
  output logic       recvAck,
  output logic       busy,
  output logic       cmdErr
);

  logic [2:0]             r_state;
  logic [1:0]             r_q;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_read;
  logic                   r_ack_en;
  logic                   r_owned;
  logic                   r_busy;
  logic                   r_fin;
  logic                   r_scl_low;
  logic                   r_sda_low;
  logic [7:0]             r_dout;
  logic                   r_dstrb;
  logic                   r_rack;
  logic                   r_err;
  logic [SYNC_STAGES-1:0] r_scl_s;
  logic [SYNC_STAGES-1:0] r_sda_s;
  logic [SYNC_STAGES-1:0] r_rel;

  logic w_tick;
  logic w_hold;
  logic w_scl_s;
  logic w_sda_s;
  logic w_rel_d;
  logic w_stretch_ph;
  cmd_e w_cmd;

  assign scl = r_scl_low ? 1'b0 : 1'bz;
  assign sda = r_sda_low ? 1'b0 : 1'bz;

  assign dOut       = r_dout;
  assign dOutStrobe = r_dstrb;
  assign recvAck    = r_rack;
  assign busy       = r_busy;
  assign cmdErr     = r_err;

  assign w_scl_s = r_scl_s[SYNC_STAGES-1];
  assign w_sda_s = r_sda_s[SYNC_STAGES-1];
  assign w_rel_d = r_rel[SYNC_STAGES-1];
  assign w_cmd   = f_cmd_sel(start, stop, write, read);

  // Our own SCL release is delayed through a pipe matching the input
  // synchroniser, so only a slave holding SCL past our release stalls the tick.
  assign w_stretch_ph = ((r_state == ST_BIT) || (r_state == ST_ACK) ||
                         (r_state == ST_RSTART) || (r_state == ST_STOP)) &&
                        ((r_q == Q1) || (r_q == Q2));
  assign w_hold = w_stretch_ph && w_rel_d && !w_scl_s;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_scl_s <= '1;
      r_sda_s <= '1;
      r_rel   <= '1;
    end else begin
      r_scl_s[0] <= scl;
      r_sda_s[0] <= sda;
      r_rel[0]   <= !r_scl_low;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_scl_s[i] <= r_scl_s[i-1];
        r_sda_s[i] <= r_sda_s[i-1];
        r_rel[i]   <= r_rel[i-1];
      end
    end
  end

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk  (clk),
    .i_rst_n(nReset),
    .i_en   (r_busy && !r_fin),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_q       <= Q0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_read    <= 1'b0;
      r_ack_en  <= 1'b0;
      r_owned   <= 1'b0;
      r_busy    <= 1'b0;
      r_fin     <= 1'b0;
      r_scl_low <= 1'b0;
      r_sda_low <= 1'b0;
      r_dout    <= '0;
      r_dstrb   <= 1'b0;
      r_rack    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dstrb <= 1'b0;
      r_err   <= 1'b0;
      if (r_fin) begin
        r_busy <= 1'b0;
        r_fin  <= 1'b0;
      end
      if (!r_busy) begin
        case (w_cmd)
          CMD_START: begin
            r_busy  <= 1'b1;
            r_shift <= {dIn[7:1], readNWrite};
            r_read  <= 1'b0;
            r_bit   <= '0;
            r_q     <= Q0;
            if (r_owned) begin
              r_state   <= ST_RSTART;
              r_sda_low <= 1'b0;
            end else begin
              r_state   <= ST_START;
              r_sda_low <= 1'b1;
            end
          end
          CMD_STOP: begin
            if (r_owned) begin
              r_busy    <= 1'b1;
              r_state   <= ST_STOP;
              r_q       <= Q0;
              r_sda_low <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
          CMD_WRITE: begin
            if (r_owned) begin
              r_busy    <= 1'b1;
              r_state   <= ST_BIT;
              r_q       <= Q0;
              r_bit     <= '0;
              r_shift   <= dIn;
              r_read    <= 1'b0;
              r_sda_low <= !dIn[7];
            end else begin
              r_err <= 1'b1;
            end
          end
          CMD_READ: begin
            if (r_owned) begin
              r_busy    <= 1'b1;
              r_state   <= ST_BIT;
              r_q       <= Q0;
              r_bit     <= '0;
              r_read    <= 1'b1;
              r_ack_en  <= sendAck;
              r_sda_low <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        case (r_state)
          ST_START: begin
            if (r_q == Q0) begin
              r_scl_low <= 1'b1;
            end else begin
              r_state   <= ST_BIT;
              r_q       <= Q0;
              r_sda_low <= !r_shift[7];
            end
          end
          ST_RSTART: begin
            case (r_q)
              Q0: r_scl_low <= 1'b0;
              Q1: r_sda_low <= 1'b1;
              Q2: r_scl_low <= 1'b1;
              default: begin
                r_state   <= ST_BIT;
                r_sda_low <= !r_shift[7];
              end
            endcase
          end
          ST_BIT: begin
            case (r_q)
              Q0: r_scl_low <= 1'b0;
              Q2: begin
                r_scl_low <= 1'b1;
                r_shift   <= {r_shift[6:0], w_sda_s};
                if (r_read && (r_bit == 3'd7)) begin
                  r_dout  <= {r_shift[6:0], w_sda_s};
                  r_dstrb <= 1'b1;
                end
              end
              Q3: begin
                if (r_bit == 3'd7) begin
                  r_state   <= ST_ACK;
                  r_sda_low <= r_read && r_ack_en;
                end else begin
                  r_bit     <= r_bit + 3'd1;
                  r_sda_low <= !r_read && !r_shift[7];
                end
              end
              default: ;
            endcase
          end
          ST_ACK: begin
            case (r_q)
              Q0: r_scl_low <= 1'b0;
              Q2: begin
                r_scl_low <= 1'b1;
                if (!r_read) r_rack <= !w_sda_s;
              end
              Q3: begin
                r_state <= ST_HOLD;
                r_owned <= 1'b1;
                r_fin   <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_STOP: begin
            case (r_q)
              Q0: r_scl_low <= 1'b0;
              Q2: r_sda_low <= 1'b0;
              Q3: begin
                r_state <= ST_IDLE;
                r_owned <= 1'b0;
                r_fin   <= 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
